// File: rtl/sram_array_pkg.sv
// sram_array_pkg: shared types and limits for the n-way SRAM array
package sram_array_pkg;
   typedef enum logic [1:0] {
      PPR_NONE = 2'd0,
      PPR_SOFT = 2'd1,
      PPR_HARD = 2'd2,
      PPR_RSVD = 2'd3
   } ppr_type_e;
   typedef enum logic {INIT, READY} arr_state_e;
   localparam int MAX_RD_LAT = 3;
endpackage

// File: rtl/ppr_event_fifo.sv
// ppr_event_fifo: first-word-fall-through event queue with sticky overflow flag
module ppr_event_fifo
   import sram_array_pkg::*;
#(
   parameter int W = 28,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         empty,
   output logic         ovf
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0] wp, rp;
   logic full, take, put;
   assign empty = wp == rp;
   assign full = wp == {~rp[AW], rp[AW-1:0]};
   assign take = pop && !empty;
   assign put = push && (!full || take);
   assign dout = mem[rp[AW-1:0]];
   // pointers advance on accepted push/pop; a refused push latches overflow
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wp <= '0;
         rp <= '0;
         ovf <= 1'b0;
      end else begin
         wp <= wp + {{AW{1'b0}}, put};
         rp <= rp + {{AW{1'b0}}, take};
         ovf <= ovf || (push && !put);
      end
   // entry storage; a full queue popping this cycle reuses the head slot
   always_ff @(posedge clk)
      if (put) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/sram_nway_array_v2.sv
// sram_nway_array_v2: n-way set-associative array with bypassed pipelined reads and PPR event queue
module sram_nway_array_v2
   import sram_array_pkg::*;
#(
   parameter int N_WAY = 4,
   parameter int IDX_SIZE = 4,
   parameter int TAG_SIZE = 20,
   parameter int SYN_W = 32,
   parameter int CNT_W = 15,
   parameter int DATA_W = 272,
   parameter int RD_LAT = 1,
   parameter int PPR_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   output logic                        rdy_o,
   input  logic                        rd_en_i,
   input  logic [IDX_SIZE-1:0]         rd_idx_i,
   output logic                        rvalid_o,
   output logic [N_WAY-1:0]            rdata_valid_o,
   output logic [2*N_WAY-1:0]          rdata_type_o,
   output logic [SYN_W*N_WAY-1:0]      rdata_syn_o,
   output logic [TAG_SIZE*N_WAY-1:0]   rdata_tag_o,
   output logic [CNT_W*N_WAY-1:0]      rdata_cnt_o,
   output logic [DATA_W*N_WAY-1:0]     rdata_data_o,
   input  logic                        wr_en_i,
   input  logic                        wr_inv_i,
   input  logic [IDX_SIZE-1:0]         wr_idx_i,
   input  logic [$clog2(N_WAY)-1:0]    wr_way_i,
   input  logic [1:0]                  wr_type_i,
   input  logic [SYN_W-1:0]            wr_syn_i,
   input  logic [TAG_SIZE-1:0]         wr_tag_i,
   input  logic [CNT_W-1:0]            wr_cnt_i,
   input  logic [DATA_W-1:0]           wr_data_i,
   output logic                        ppr_valid_o,
   input  logic                        ppr_ready_i,
   output logic [1:0]                  ppr_type_o,
   output logic [IDX_SIZE-1:0]         ppr_idx_o,
   output logic [$clog2(N_WAY)-1:0]    ppr_way_o,
   output logic [TAG_SIZE-1:0]         ppr_tag_o,
   output logic                        ppr_ovf_o
);
   localparam int NUM_IDX = 2**IDX_SIZE;
   localparam int WW = $clog2(N_WAY);
   localparam int LAT = RD_LAT < 1 ? 1 : RD_LAT > MAX_RD_LAT ? MAX_RD_LAT : RD_LAT;
   localparam int O_CNT = DATA_W;
   localparam int O_TAG = O_CNT + CNT_W;
   localparam int O_SYN = O_TAG + TAG_SIZE;
   localparam int O_TYP = O_SYN + SYN_W;
   localparam int FW = O_TYP + 2;
   localparam int RW = FW + 1;
   localparam int EW = 2 + IDX_SIZE + WW + TAG_SIZE;

   arr_state_e state, state_n;
   logic [IDX_SIZE-1:0] cnt, cnt_n;
   logic [N_WAY-1:0] vld [NUM_IDX];
   logic [FW-1:0] fld [NUM_IDX][N_WAY];
   logic [LAT-1:0] pv;
   logic [N_WAY*RW-1:0] pd [LAT];
   logic [N_WAY*RW-1:0] rec, rout;
   logic [FW-1:0] wfld;
   logic [EW-1:0] head;
   logic ready, rd_acc, wr_acc, push, empty;

   assign ready = state == READY;
   assign rdy_o = ready;
   assign rd_acc = ready && rd_en_i;
   assign wr_acc = ready && wr_en_i;
   assign wfld = {wr_type_i, wr_syn_i, wr_tag_i, wr_cnt_i, wr_data_i};
   assign push = wr_acc && !wr_inv_i && (wr_type_i == PPR_SOFT || wr_type_i == PPR_HARD);

   // state and sweep counter
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= INIT;
         cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
      end

   // walk one set per cycle in INIT, open the array once the last set is cleared
   always_comb begin
      state_n = (state == INIT && &cnt) ? READY : state;
      cnt_n = (state == INIT) ? cnt + 1'b1 : cnt;
   end

   // sweep clears valid bits; writes set or clear one way, invalidates leave fields alone
   always_ff @(posedge clk) begin
      if (!ready) vld[cnt] <= '0;
      else if (wr_en_i) vld[wr_idx_i][wr_way_i] <= !wr_inv_i;
      if (wr_acc && !wr_inv_i) fld[wr_idx_i][wr_way_i] <= wfld;
   end

   // read valid pipeline, flushed by reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) pv <= '0;
      else pv <= LAT'({pv, rd_acc});

   // read data pipeline; a stage never sees writes that land after its capture
   always_ff @(posedge clk) begin
      if (rd_acc) pd[0] <= rec;
      for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
   end

   assign rvalid_o = pv[LAT-1];
   assign rout = pv[LAT-1] ? pd[LAT-1] : '0;

   for (genvar g = 0; g < N_WAY; g++) begin : g_way
      logic hit;
      assign hit = wr_acc && wr_idx_i == rd_idx_i && wr_way_i == WW'(g);
      assign rec[g*RW +: RW] = hit ? {!wr_inv_i, wr_inv_i ? fld[rd_idx_i][g] : wfld}
                                   : {vld[rd_idx_i][g], fld[rd_idx_i][g]};
      assign rdata_valid_o[g] = rout[g*RW + FW];
      assign rdata_type_o[g*2 +: 2] = rout[g*RW + O_TYP +: 2];
      assign rdata_syn_o[g*SYN_W +: SYN_W] = rout[g*RW + O_SYN +: SYN_W];
      assign rdata_tag_o[g*TAG_SIZE +: TAG_SIZE] = rout[g*RW + O_TAG +: TAG_SIZE];
      assign rdata_cnt_o[g*CNT_W +: CNT_W] = rout[g*RW + O_CNT +: CNT_W];
      assign rdata_data_o[g*DATA_W +: DATA_W] = rout[g*RW +: DATA_W];
   end

   ppr_event_fifo #(.W(EW), .DEPTH(PPR_DEPTH)) u_fifo (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push),
      .pop  (ppr_ready_i),
      .din  ({wr_type_i, wr_idx_i, wr_way_i, wr_tag_i}),
      .dout (head),
      .empty(empty),
      .ovf  (ppr_ovf_o)
   );

   assign ppr_valid_o = !empty;
   assign {ppr_type_o, ppr_idx_o, ppr_way_o, ppr_tag_o} = head;
endmodule
